// File: rtl/alu_packet_decoder_if.sv
// Stream bundle between the UART receiver, the packet decoder and the ALU.
// The slave modport is the decoder's view; master is the environment driving it.
interface alu_packet_decoder_if #(
  parameter int unsigned WIDTH_P = 32
);
  logic [7:0]         rx_data_i;
  logic               rx_valid_i;
  logic               rx_ready_o;
  logic [7:0]         opcode_o;
  logic [WIDTH_P-1:0] op_data_o;
  logic               op_valid_o;
  logic               op_ready_i;
  logic               op_last_o;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  rx_data_i, rx_valid_i, op_ready_i,
    output rx_ready_o, opcode_o, op_data_o, op_valid_o, op_last_o, busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i, op_ready_i,
    input  rx_ready_o, opcode_o, op_data_o, op_valid_o, op_last_o, busy_o, err_o
  );
endinterface

// File: rtl/alu_packet_decoder.sv
// Parses opcode / reserved / len / operand frames from the UART byte stream and
// emits operand words as a valid/ready stream; unsupported frames are drained.
module alu_packet_decoder #(
  parameter int unsigned WIDTH_P      = 32,
  parameter logic [7:0]  OPCODE_ADD_P = 8'h10,
  parameter logic [7:0]  OPCODE_MUL_P = 8'h11
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  alu_packet_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_OUT,
    S_DRAIN
  } state_t;

  state_t             state_reg;
  logic [7:0]         opcode_reg;
  logic [WIDTH_P-1:0] word_reg;
  logic [15:0]        remaining_reg;
  logic [1:0]         byte_idx_reg;
  logic               err_reg;

  logic               accept;
  logic [15:0]        len_full;
  logic               opcode_ok;

  assign accept    = bus.rx_valid_i && (state_reg != S_OUT);
  // LEN_LO parks the low length byte in the bottom of the remaining counter.
  assign len_full  = {bus.rx_data_i, remaining_reg[7:0]};
  assign opcode_ok = (opcode_reg == OPCODE_ADD_P) || (opcode_reg == OPCODE_MUL_P);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_OPCODE;
      opcode_reg    <= 8'h00;
      word_reg      <= '0;
      remaining_reg <= 16'h0000;
      byte_idx_reg  <= 2'd0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        S_OPCODE: begin
          if (accept) begin
            opcode_reg <= bus.rx_data_i;
            state_reg  <= S_RSVD;
          end
        end
        S_RSVD: begin
          if (accept) state_reg <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (accept) begin
            remaining_reg <= {8'h00, bus.rx_data_i};
            state_reg     <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            remaining_reg <= len_full;
            byte_idx_reg  <= 2'd0;
            if (len_full == 16'h0000) begin
              err_reg   <= 1'b1;
              state_reg <= S_OPCODE;
            end else if (!opcode_ok) begin
              err_reg   <= 1'b1;
              state_reg <= S_DRAIN;
            end else begin
              state_reg <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg[{byte_idx_reg, 3'b000} +: 8] <= bus.rx_data_i;
            byte_idx_reg                          <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.op_ready_i) begin
            if (remaining_reg == 16'd1) begin
              state_reg <= S_OPCODE;
            end else begin
              remaining_reg <= remaining_reg - 16'd1;
              state_reg     <= S_DATA;
            end
          end
        end
        S_DRAIN: begin
          // Same byte/word bookkeeping as DATA, but nothing is stored or emitted.
          if (accept) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              if (remaining_reg == 16'd1) state_reg <= S_OPCODE;
              else remaining_reg <= remaining_reg - 16'd1;
            end
          end
        end
        default: state_reg <= S_OPCODE;
      endcase
    end
  end

  assign bus.rx_ready_o = (state_reg != S_OUT);
  assign bus.op_valid_o = (state_reg == S_OUT);
  assign bus.op_last_o  = (state_reg == S_OUT) && (remaining_reg == 16'd1);
  assign bus.busy_o     = (state_reg != S_OPCODE);
  assign bus.err_o      = err_reg;
  assign bus.opcode_o   = opcode_reg;
  assign bus.op_data_o  = word_reg;

endmodule

// File: tb/tb_alu_packet_decoder.sv
// Directed and randomised frames against a frame-level model of the decoder;
// a single monitor checks every operand beat, hold behaviour and error pulses.
module tb_alu_packet_decoder;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  op;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   exp_err = 0;
  bit   rand_ready = 1'b0;
  bit   last_bad;

  logic [7:0] frm[$];
  beat_t      exp_q[$];
  beat_t      obs_q[$];

  alu_packet_decoder_if #(.WIDTH_P(32)) bus();

  alu_packet_decoder #(
    .WIDTH_P(32),
    .OPCODE_ADD_P(8'h10),
    .OPCODE_MUL_P(8'h11)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a supported opcode with nonzero len yields len words, little-endian.
  task automatic expect_frame();
    logic [15:0] len;
    beat_t       b;
    len = {frm[3], frm[2]};
    last_bad = (len == 16'd0) || !(frm[0] == 8'h10 || frm[0] == 8'h11);
    if (last_bad) exp_err++;
    else begin
      for (int k = 0; k < int'(len); k++) begin
        b.data = {frm[4*k+7], frm[4*k+6], frm[4*k+5], frm[4*k+4]};
        b.last = (k == int'(len) - 1);
        b.op   = frm[0];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    frm.push_back(w[7:0]);
    frm.push_back(w[15:8]);
    frm.push_back(w[23:16]);
    frm.push_back(w[31:24]);
  endtask

  task automatic new_frame(input logic [7:0] op, input logic [7:0] rsvd, input logic [15:0] len);
    frm.delete();
    frm.push_back(op);
    frm.push_back(rsvd);
    frm.push_back(len[7:0]);
    frm.push_back(len[15:8]);
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rx_ready_o && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: got no rx_ready expected rx_ready within 5000 cycles");
      finish_now();
    end
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int gmax, input bit chk_err);
    expect_frame();
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
      if (chk_err && i == 3) begin
        @(negedge clk); chk("err_pulse", bus.err_o, {31'd0, last_bad});
        @(negedge clk); chk("err_one_cycle", bus.err_o, 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy_o) && n < 2000) begin @(negedge clk); n++; end
    chk("idle_within_budget", {31'd0, n < 2000}, 1);
    chk("busy_when_idle", bus.busy_o, 0);
    chk("model_queue_empty", exp_q.size(), 0);
    chk("err_count", err_seen, exp_err);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_op_valid"}, bus.op_valid_o, 0);
    chk({tag, "_op_last"}, bus.op_last_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_opcode"}, bus.opcode_o, 0);
    chk({tag, "_op_data"}, bus.op_data_o, 0);
  endtask

  // Monitor: every valid beat against the model, hold under backpressure, err pulse width.
  initial begin
    logic        prev_hold;
    logic        prev_err;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [7:0]  prev_op;
    beat_t       ob;
    prev_hold = 1'b0;
    prev_err  = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    prev_op   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", bus.op_valid_o, 1);
          chk("hold_data", bus.op_data_o, prev_data);
          chk("hold_last", bus.op_last_o, {31'd0, prev_last});
          chk("hold_opcode", bus.opcode_o, prev_op);
        end
        if (bus.op_valid_o) begin
          chk("rx_ready_in_out", bus.rx_ready_o, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", bus.op_data_o);
          end else begin
            chk("beat_data", bus.op_data_o, exp_q[0].data);
            chk("beat_last", bus.op_last_o, {31'd0, exp_q[0].last});
            chk("beat_opcode", bus.opcode_o, exp_q[0].op);
            if (bus.op_ready_i) exp_q.delete(0);
          end
          if (bus.op_ready_i) begin
            ob.data = bus.op_data_o;
            ob.last = bus.op_last_o;
            ob.op   = bus.opcode_o;
            obs_q.push_back(ob);
          end
        end
        if (bus.err_o) begin
          err_seen++;
          if (prev_err) begin
            checks++;
            errors++;
            $display("FAIL err_width: got err high 2 cycles expected 1");
          end
        end
        prev_err  = bus.err_o;
        prev_hold = bus.op_valid_o && !bus.op_ready_i;
        prev_data = bus.op_data_o;
        prev_last = bus.op_last_o;
        prev_op   = bus.opcode_o;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.op_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int base;
    int nlen;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.op_ready_i = 1'b0;

    // Reset values
    #2;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    chk("reset_rx_ready", bus.rx_ready_o, 1);
    @(posedge clk); #1;

    // ADD frame, no backpressure
    bus.op_ready_i = 1'b1;
    base = obs_q.size();
    new_frame(8'h10, 8'h00, 16'd2);
    push_word(32'd1);
    push_word(32'd2);
    send_frame(0, 1'b1);
    wait_idle();
    chk("add_beats", obs_q.size() - base, 2);
    if (obs_q.size() - base == 2) begin
      chk("add_w0", obs_q[base].data, 32'd1);
      chk("add_l0", {31'd0, obs_q[base].last}, 0);
      chk("add_w1", obs_q[base+1].data, 32'd2);
      chk("add_l1", {31'd0, obs_q[base+1].last}, 1);
    end
    chk("add_opcode", bus.opcode_o, 32'h10);
    chk("add_no_err", err_seen, 0);

    // Backpressure on a single-operand MUL frame
    bus.op_ready_i = 1'b0;
    base = obs_q.size();
    new_frame(8'h11, 8'h00, 16'd1);
    push_word(32'h12345678);
    send_frame(0, 1'b0);
    @(negedge clk);
    chk("bp_latency_valid", bus.op_valid_o, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", bus.op_data_o, 32'h12345678);
      chk("bp_last", bus.op_last_o, 1);
      chk("bp_rx_ready", bus.rx_ready_o, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.op_ready_i = 1'b1;
    wait_idle();
    chk("bp_beats", obs_q.size() - base, 1);

    // Unsupported opcode is drained, following ADD frame decodes
    base = obs_q.size();
    new_frame(8'h7F, 8'h00, 16'd1);
    push_word(32'hDDCCBBAA);
    send_frame(0, 1'b1);
    new_frame(8'h10, 8'h5A, 16'd2);
    push_word(32'd3);
    push_word(32'd4);
    send_frame(1, 1'b0);
    wait_idle();
    chk("unsup_beats", obs_q.size() - base, 2);
    if (obs_q.size() - base == 2) begin
      chk("unsup_w0", obs_q[base].data, 32'd3);
      chk("unsup_w1", obs_q[base+1].data, 32'd4);
      chk("unsup_l1", {31'd0, obs_q[base+1].last}, 1);
    end
    chk("unsup_err_total", err_seen, 1);

    // Zero length
    new_frame(8'h10, 8'h00, 16'd0);
    send_frame(0, 1'b1);
    @(negedge clk);
    chk("zero_len_idle", bus.busy_o, 0);
    @(posedge clk); #1;
    new_frame(8'h10, 8'hFF, 16'd2);
    push_word(32'hCAFEF00D);
    push_word(32'h0BADBEEF);
    send_frame(2, 1'b0);
    wait_idle();

    // Reset mid-frame: six bytes of a len-2 frame, then async reset
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = obs_q.size();
    new_frame(8'h11, 8'h00, 16'd2);
    push_word(32'h00000005);
    push_word(32'h00000006);
    send_frame(0, 1'b0);
    wait_idle();
    chk("midreset_beats", obs_q.size() - base, 2);
    if (obs_q.size() - base == 2) chk("midreset_w0", obs_q[base].data, 32'd5);

    // Fuzz
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      nlen = int'($urandom_range(2, 15));
      new_frame(($urandom_range(0, 1) == 0) ? 8'h10 : 8'h11, 8'($urandom), 16'(nlen));
      for (int k = 0; k < nlen; k++) push_word($urandom);
      send_frame(3, 1'b0);
    end
    rand_ready = 1'b0;
    #1 bus.op_ready_i = 1'b1;
    wait_idle();

    finish_now();
  end

endmodule

// File: doc/alu_packet_decoder.md
# alu_packet_decoder

Receive-side packet decoder for the UART ALU. It sits between the UART receiver byte stream and the ALU datapath. It parses the host command frame: opcode, reserved byte, 16-bit operand count, then 32-bit operands. It emits the opcode plus a valid/ready stream of operand words with a last flag, and it discards frames whose opcode is not supported.

## Interface
Parameters:
- `WIDTH_P`, 32, operand width in bits; always 4 bytes per operand.
- `OPCODE_ADD_P`, 8'h10, accepted opcode (add).
- `OPCODE_MUL_P`, 8'h11, accepted opcode (multiply).

Ports:
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `rx_data_i` input 8: byte from the UART receiver.
- `rx_valid_i` input 1: `rx_data_i` is valid.
- `rx_ready_o` output 1: decoder accepts a byte this cycle.
- `opcode_o` output 8: opcode of the current frame, held from the OPCODE byte until the next OPCODE byte.
- `op_data_o` output `WIDTH_P`: operand word.
- `op_valid_o` output 1: `op_data_o` is valid.
- `op_ready_i` input 1: ALU accepts the operand.
- `op_last_o` output 1: qualifies the final operand of the frame.
- `busy_o` output 1: high in every state except OPCODE.
- `err_o` output 1: one-cycle pulse for an unsupported opcode or zero length.

## Operation
- A byte is accepted when `rx_valid_i && rx_ready_o`.
- Frame layout (all fields LSB first): opcode, reserved (ignored), len[7:0], len[15:8], then len operands of 4 bytes each.
- `len` counts operands, not bytes.
- States:
  - OPCODE: accept a byte, latch it into `opcode_o`, go to RSVD.
  - RSVD: accept a byte, go to LEN_LO.
  - LEN_LO: latch the low byte of `len`, go to LEN_HI.
  - LEN_HI: latch the high byte of `len`.
    - `len==0`: pulse `err_o`, go to OPCODE.
    - Opcode not ADD/MUL: pulse `err_o`, go to DRAIN.
    - Otherwise: go to DATA.
  - DATA: shift bytes into the word register at positions 0..3 (2-bit byte index). After byte index 3 is accepted, go to OUT.
  - OUT: `op_valid_o=1`, `rx_ready_o=0`. Hold the word until `op_ready_i`.
    - On the transfer: if remaining==1, go to OPCODE; else decrement remaining and go to DATA.
  - DRAIN: accept and discard 4·len bytes, then go to OPCODE. No `op_valid_o` is raised.
- `op_last_o` = (state==OUT && remaining==1). It is meaningful only while `op_valid_o` is high.
- Remaining counter: 16 bits, loaded from `len`. It never wraps, because `len==0` is rejected in LEN_HI.
- `rx_ready_o` = 1 in every state except OUT.

## Timing
- Reset (async assert, synchronous release to the FSM):
  - state = OPCODE.
  - `rx_ready_o`=1 (combinational from state; high once `rst_ni` deasserts), `op_valid_o`=0, `op_last_o`=0, `busy_o`=0, `err_o`=0.
  - `opcode_o`=0, `op_data_o`=0, counters=0.
- Latency: `op_valid_o` rises the cycle after the 4th byte of an operand is accepted.
- Backpressure:
  - `op_data_o`, `op_last_o` and `opcode_o` are stable while `op_valid_o && !op_ready_i`.
  - No byte is consumed while in OUT.
  - The upstream UART FIFO absorbs bytes during this time.
- A transfer at OUT with `op_ready_i` already high takes exactly 1 cycle in OUT. Throughput is bounded by the byte rate, not by OUT.
- `err_o` is asserted for exactly the cycle following the accepted LEN_HI byte.
- The reserved byte is ignored for any value.
- Bytes arriving while `rx_valid_i` is low are not counted. Gaps of any length are legal in every state.
- If `rst_ni` is asserted mid-frame, the partial frame is dropped, and the next byte after release is treated as an opcode.
- `len`=16'hFFFF is legal: 65535 operands with a single `op_last_o` at the end.

## Test plan
- **ADD frame, no backpressure.** Stimulus: 10 00 02 00 01 00 00 00 02 00 00 00 with `op_ready_i`=1. Response: two beats, 32'd1 (last=0) then 32'd2 (last=1); `opcode_o`=8'h10; `err_o` never asserts; `busy_o` low afterwards.
- **Backpressure.** Stimulus: MUL frame 11 00 01 00 78 56 34 12 with `op_ready_i` held low for 20 cycles. Response: `op_data_o`=32'h12345678 and `op_last_o`=1 stable throughout; `rx_ready_o`=0 throughout; a single beat when `op_ready_i` rises.
- **Unsupported opcode.** Stimulus: 7F 00 01 00 AA BB CC DD, then a valid ADD frame with operands 3 and 4. Response: one `err_o` pulse; no operand beats for the first frame; the ADD frame yields 3 and then 4 (last).
- **Zero length.** Stimulus: 10 00 00 00, then an ADD frame of len 2. Response: one `err_o` pulse; return to OPCODE; the second frame decodes normally.
- **Reset mid-frame.** Stimulus: assert `rst_ni` low after 6 bytes of a len-2 frame, release, then send a full frame. Response: all outputs at their reset values; only the new frame's operands appear.
- **Fuzz.** Stimulus: 100 random frames, len 2..15, random `rx_valid_i` gaps and random `op_ready_i`. Response: the bench-reconstructed word sequence and last flags match the sent data exactly.
